// File: rtl/pc_unit_if.sv
// Command/status bundle between the sequencer and the program-counter stage.
// The master drives the step commands; the slave (pc_unit) returns the PC and its flags.
interface pc_unit_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             jmp;
    logic             call;
    logic             ret;
    logic             halt;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] addr;
    logic             halted;
    logic             fault;
    logic             stack_empty;
    logic             stack_full;

    modport master (
        output en, jmp, call, ret, halt, target,
        input  addr, halted, fault, stack_empty, stack_full
    );

    modport slave (
        input  en, jmp, call, ret, halt, target,
        output addr, halted, fault, stack_empty, stack_full
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with absolute jump, halt and an optional return-address stack.
// Define PC_STACK_EN to build in call/ret stack storage and stack-error FAULT.
module pc_unit #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] w_addr_inc;
    logic             w_step;

    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_unit: STACK_DEPTH must be a power of two and at least 2");
    end

    assign w_addr_inc = r_addr + WIDTH'(1);
    assign w_step     = bus.en && (r_state == S_RUN);

`ifdef PC_STACK_EN
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [SP_W-1:0]  r_sp;
    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]  w_sp_dec;
    logic             w_empty;
    logic             w_full;
    logic             w_push;

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == SP_W'(STACK_DEPTH));
    assign w_sp_dec = r_sp - SP_W'(1);
    // Push only when call is the winning command and the stack has room.
    assign w_push   = w_step && !bus.halt && !bus.ret && bus.call && !w_full;

    // Stack storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp[IDX_W-1:0]] <= w_addr_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_addr  <= '0;
            r_sp    <= '0;
        end else if (w_step) begin
            if (bus.halt) begin
                r_state <= S_HALTED;
            end else if (bus.ret) begin
                if (w_empty) begin
                    r_state <= S_FAULT;
                end else begin
                    r_sp   <= w_sp_dec;
                    r_addr <= r_stack[w_sp_dec[IDX_W-1:0]];
                end
            end else if (bus.call) begin
                if (w_full) begin
                    r_state <= S_FAULT;
                end else begin
                    r_sp   <= r_sp + SP_W'(1);
                    r_addr <= bus.target;
                end
            end else if (bus.jmp) begin
                r_addr <= bus.target;
            end else begin
                r_addr <= w_addr_inc;
            end
        end
    end

    assign bus.stack_empty = w_empty;
    assign bus.stack_full  = w_full;
    assign bus.fault       = (r_state == S_FAULT);
`else
    // Without a stack, call degenerates to jmp and ret falls through to increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_addr  <= '0;
        end else if (w_step) begin
            if (bus.halt) begin
                r_state <= S_HALTED;
            end else if (bus.call || bus.jmp) begin
                r_addr <= bus.target;
            end else begin
                r_addr <= w_addr_inc;
            end
        end
    end

    assign bus.stack_empty = 1'b1;
    assign bus.stack_full  = 1'b0;
    assign bus.fault       = 1'b0;
`endif

    assign bus.addr   = r_addr;
    assign bus.halted = (r_state != S_RUN);
endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized bench for pc_unit against a queue-based reference model.
// Follows whichever PC_STACK_EN build is being compiled.
module tb_pc_unit;
    localparam int W     = 8;
    localparam int DEPTH = 4;
`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_unit_if #(.WIDTH(W)) bus ();

    pc_unit #(.WIDTH(W), .STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: PC as an integer, return stack as a queue.
    int m_addr;
    int m_stack[$];
    bit m_halted;
    bit m_fault;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".addr"},   32'(bus.addr),        32'(m_addr));
        chk({tag, ".halted"}, 32'(bus.halted),      32'(m_halted));
        chk({tag, ".fault"},  32'(bus.fault),       32'(m_fault));
        chk({tag, ".empty"},  32'(bus.stack_empty), 32'(m_stack.size() == 0));
        chk({tag, ".full"},   32'(bus.stack_full),  32'(m_stack.size() == DEPTH));
    endtask

    function automatic void model(input bit en, input bit j, input bit c, input bit r,
                                  input bit h, input int tgt);
        if (m_halted || !en) return;
        if (h) begin
            m_halted = 1'b1;
        end else if (STK && r) begin
            if (m_stack.size() == 0) begin
                m_halted = 1'b1;
                m_fault  = 1'b1;
            end else begin
                m_addr = m_stack.pop_back();
            end
        end else if (STK && c) begin
            if (m_stack.size() == DEPTH) begin
                m_halted = 1'b1;
                m_fault  = 1'b1;
            end else begin
                m_stack.push_back((m_addr + 1) % 256);
                m_addr = tgt;
            end
        end else if (c || j) begin
            m_addr = tgt;
        end else begin
            m_addr = (m_addr + 1) % 256;
        end
    endfunction

    // Called at posedge+1; drives inputs, waits one edge, updates the model.
    task automatic step(input bit en, input bit j, input bit c, input bit r,
                        input bit h, input int tgt);
        bus.en     = en;
        bus.jmp    = j;
        bus.call   = c;
        bus.ret    = r;
        bus.halt   = h;
        bus.target = W'(tgt);
        @(posedge clk);
        #1;
        model(en, j, c, r, h, tgt);
    endtask

    task automatic do_reset(input string tag);
        bus.en = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.halt = 1'b0;
        rst = 1'b1;
        #1;
        m_addr = 0; m_stack.delete(); m_halted = 1'b0; m_fault = 1'b0;
        chk_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.halt = 1'b0;
        bus.target = '0;
        m_addr = 0; m_halted = 1'b0; m_fault = 1'b0;
        #3;
        chk_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential count 1..5 with explicit expected values.
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0, 0, 0, 0);
            chk("count", 32'(bus.addr), 32'(i));
        end
        // Asynchronous reset with no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.addr", 32'(bus.addr), 32'd0);
        m_addr = 0; m_stack.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wrap and jump.
        step(1, 1, 0, 0, 0, 8'hFE); chk("jmp_fe", 32'(bus.addr), 32'hFE);
        step(1, 0, 0, 0, 0, 0);     chk("inc_ff", 32'(bus.addr), 32'hFF);
        step(1, 0, 0, 0, 0, 0);     chk("wrap",   32'(bus.addr), 32'h00);

        // jmp+call at 0x05.
        do_reset("rst_a");
        step(1, 1, 0, 0, 0, 8'h05);
        step(1, 1, 1, 0, 0, 8'h20); chk_all("jmp_call");
        chk("jmp_call.addr", 32'(bus.addr), 32'h20);

        // Nested calls and returns.
        do_reset("rst_b");
        step(1, 1, 0, 0, 0, 8'h03);
        step(1, 0, 1, 0, 0, 8'h10); chk_all("call1");
        step(1, 0, 0, 0, 0, 0);     chk_all("inc11");
        step(1, 0, 1, 0, 0, 8'h30); chk_all("call2");
        step(1, 0, 0, 1, 0, 0);     chk_all("ret1");
        step(1, 0, 0, 1, 0, 0);     chk_all("ret2");
        if (STK) chk("ret2.addr", 32'(bus.addr), 32'h04);

        // Overflow.
        do_reset("rst_c");
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 1, 0, 0, 8'h40 + i);
            chk_all("fill");
        end
        step(1, 0, 1, 0, 0, 8'h80); chk_all("overflow");
        step(1, 1, 0, 0, 0, 8'h99); chk_all("post_ovf_jmp");
        step(1, 0, 0, 1, 0, 0);     chk_all("post_ovf_ret");

        // Underflow from reset.
        do_reset("rst_d");
        step(1, 0, 0, 1, 0, 0);     chk_all("underflow");
        step(1, 0, 0, 0, 0, 0);     chk_all("post_unf");

        // Halt at 0x07 holds for 10 cycles.
        do_reset("rst_e");
        step(1, 1, 0, 0, 0, 8'h07);
        step(1, 0, 0, 0, 1, 0);     chk_all("halt");
        chk("halt.addr", 32'(bus.addr), 32'h07);
        for (int i = 0; i < 10; i++) begin
            step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0,
                 int'($urandom_range(0, 255)));
            chk_all("halted_hold");
        end

        // en=0 hold.
        do_reset("rst_f");
        step(1, 1, 0, 0, 0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 8'h77);
            chk_all("en0_hold");
        end

        // Call/ret fallback behaviour in the stackless build.
        do_reset("rst_g");
        step(1, 0, 1, 0, 0, 8'h40); chk_all("call40");
        step(1, 0, 0, 1, 0, 0);     chk_all("ret_after_call40");

        // Randomized commands.
        do_reset("rst_r");
        for (int n = 0; n < 400; n++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset("rand_rst");
            end
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 31) == 0, int'($urandom_range(0, 255)));
            chk_all("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage for the single-cycle CPU. It sits directly upstream of the instruction ROM: its registered `addr` output drives the ROM address, so `instr`/`arg` for the current PC are valid combinationally within the same cycle. It advances sequentially, takes absolute jumps, and supports subroutine call/return through a small hardware return-address stack. It also has halt and fault states.

## Interface
- `WIDTH`, 8, address width; equals the ROM `WIDTH`.
- `STACK_DEPTH`, 4, number of return-address stack entries; power of two, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  step enable; when 0, all state holds.
- `jmp`  in  1  load `target` into PC.
- `call`  in  1  push `addr+1`, then load `target`.
- `ret`  in  1  pop the top of stack into PC.
- `halt`  in  1  enter the HALTED state.
- `target`  in  WIDTH  jump/call destination, normally the ROM `arg`.
- `addr`  out  WIDTH  current PC, registered; goes to ROM `addr`.
- `halted`  out  1  PC is frozen (HALTED or FAULT).
- `fault`  out  1  sticky stack-error flag.
- `stack_empty`  out  1  stack pointer equals 0.
- `stack_full`  out  1  stack pointer equals `STACK_DEPTH`.

## Operation
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- States:
  - RUN: reset state.
  - HALTED: entered from RUN on `en && halt`.
  - FAULT: entered from RUN on a stack error.
  - HALTED and FAULT exit only through `rst`.
- Command priority in RUN with `en=1`: `halt` > `ret` > `call` > `jmp` > increment. Only the highest-priority asserted command acts.
- Increment: `addr <= addr + 1`, modulo 2^WIDTH, so 0xFF wraps to 0x00.
- jmp: `addr <= target`.
- call:
  - Pushes `(addr + 1) mod 2^WIDTH` into `stack[sp]`.
  - Sets `sp <= sp + 1` and `addr <= target`.
- ret: sets `sp <= sp - 1` and `addr <= stack[sp-1]`.
- Stack errors:
  - call with `stack_full`, or ret with `stack_empty`, is an error.
  - On error: no push/pop, `addr` holds, `fault <= 1`, and the state goes to FAULT.
- halt: `addr` holds at its current value; the state goes to HALTED.
- In HALTED or FAULT, every input except `rst` is ignored.
- `halted` = (state != RUN). `fault` = (state == FAULT).
- `sp` is `$clog2(STACK_DEPTH)+1` bits wide. Stack contents are not reset and are unobservable until written.

## Timing
- Reset values:
  - `addr` = 0, `halted` = 0, `fault` = 0.
  - `stack_empty` = 1, `stack_full` = 0, `sp` = 0, state = RUN.
- Reset takes effect immediately on `rst` rising, with no clock required. A call/ret in flight is discarded.
- Latency:
  - A command sampled at edge N is visible on `addr` after edge N.
  - The ROM output for the new address is valid in the same cycle.
- `en=0`: no state changes, and commands are ignored (not queued).
- Flags are combinational decodes of registered `sp`/state, so they update with `addr`.
- A call into a stack with `STACK_DEPTH-1` entries succeeds and sets `stack_full` after that edge.
- A ret at `sp=1` succeeds and sets `stack_empty`.

## Configuration
- `PC_STACK_EN` defined:
  - The return-address stack, `call`/`ret` and stack-error FAULT are compiled in, as described above.
- `PC_STACK_EN` undefined:
  - No stack storage.
  - `call` behaves exactly as `jmp`.
  - `ret` is ignored, and the increment occurs as if no command were asserted.
  - FAULT is unreachable.
  - `stack_empty` is tied to 1, `stack_full` to 0, `fault` to 0.

## Test plan
- Reset then 5 cycles with `en=1`, no commands:
  - `addr` steps 0,1,2,3,4,5.
  - Asserting `rst` mid-cycle drives `addr` to 0 immediately, without a clock edge.
- Wrap and jump:
  - `jmp`, `target`=0xFE, then two increments: `addr` goes 0xFE, 0xFF, 0x00.
  - `jmp`+`call` in the same cycle with `target`=0x20 at `addr`=0x05: call wins, `addr`=0x20, and 0x06 is pushed.
- Nested calls:
  - Call 0x10 from 0x03, then call 0x30 from 0x11.
  - Two rets: `addr` goes 0x12, then 0x04.
  - `stack_empty` is 1 again at the end.
- Overflow:
  - 4 calls fill the stack (`stack_full`=1).
  - A 5th call results in `fault`=1, `halted`=1, `addr` unchanged.
  - Further commands have no effect until `rst`.
- Underflow and halt:
  - `ret` from reset results in `fault`=1, `addr`=0.
  - Separately, `halt` at 0x07 with `en=1` results in `halted`=1, `fault`=0, and `addr` stays 0x07 for 10 cycles.
- `en=0`: hold for 3 cycles with `jmp` asserted; `addr` is unchanged.
- Build without `PC_STACK_EN`:
  - `call` 0x40 results in `addr`=0x40.
  - `ret` increments `addr` to 0x41.
  - `fault` stays 0.
